uart_rxdma: RTL and testbench

Receive-side DMA engine that sits directly downstream of the UART host controller's register interface. It acts as bus master on that interface: it polls the STAT register, dequeues bytes from the DATA register (RX FIFO), and writes each byte into SRAM through a single-beat request/acknowledge port. The CPU supplies a start address and a byte count, then takes an interrupt on completion, so it no longer services each received byte.

---
 rtl/uart_rxdma.sv | 188 ++++++++++++++++++
 tb/tb_uart_rxdma.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxdma.sv
// uart_rxdma: UART receive DMA polling STAT/DATA and writing bytes to SRAM.
// Optional idle timeout is built when UART_RXDMA_TIMEOUT_EN is defined.
module uart_rxdma #(
  parameter int ADDR_BITS = 21,
  parameter int LEN_BITS  = 16,
  parameter int TMO_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic [LEN_BITS-1:0]  len_i,
  input  logic [TMO_BITS-1:0]  tmo_i,
  input  logic                 irq_ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 irq_o,
  output logic [LEN_BITS-1:0]  count_o,
  output logic                 err_o,
  output logic                 tmo_o,
  input  logic [7:0]           reg_d_i,
  output logic [7:0]           reg_d_o,
  output logic                 reg_rd_o,
  output logic                 reg_wr_o,
  output logic                 reg_cs_stat_o,
  output logic                 reg_cs_data_o,
  output logic                 mem_req_o,
  input  logic                 mem_ack_i,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [7:0]           mem_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_ECLR,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  rem_q;
  logic [LEN_BITS-1:0]  cnt_q;
  logic [7:0]           wdata_q;
  logic                 err_q;
  logic                 tmo_q;
  logic                 irq_q;
  logic                 abort_q;
  logic                 tmo_hit;

  logic stat_empty;
  logic stat_err;
  logic abort_any;
  logic start_ok;
  logic byte_done;
  logic unused_bits;

  assign stat_empty = reg_d_i[7];
  assign stat_err   = reg_d_i[5] | reg_d_i[4];
  assign abort_any  = abort_q | abort_i;
  assign start_ok   = (state_q == S_IDLE) && start_i;
  assign byte_done  = (state_q == S_WRITE) && mem_ack_i;

`ifdef UART_RXDMA_TIMEOUT_EN
  logic [TMO_BITS-1:0] idle_q;

  assign tmo_hit = (tmo_i != '0) &&
    (({1'b0, idle_q} + (TMO_BITS+1)'(1)) >= {1'b0, tmo_i});
  assign unused_bits = ^{reg_d_i[6], reg_d_i[3:0]};

  // idle counter: counts empty polls, cleared per byte and on start
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_q <= '0;
    end else if (start_ok || byte_done) begin
      idle_q <= '0;
    end else if (state_q == S_POLL && !stat_err && stat_empty && !tmo_hit) begin
      idle_q <= idle_q + TMO_BITS'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign unused_bits = ^{reg_d_i[6], reg_d_i[3:0], tmo_i};
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next state and register/memory strobes
  always_comb begin
    state_d       = state_q;
    reg_rd_o      = 1'b0;
    reg_wr_o      = 1'b0;
    reg_cs_stat_o = 1'b0;
    reg_cs_data_o = 1'b0;
    mem_req_o     = 1'b0;
    done_o        = 1'b0;
    busy_o        = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = (len_i == '0) ? S_DONE : S_POLL;
        end
      end
      S_POLL: begin
        reg_cs_stat_o = 1'b1;
        reg_rd_o      = 1'b1;
        if (stat_err)        state_d = S_ECLR;
        else if (!stat_empty) state_d = S_READ;
        else if (tmo_hit)    state_d = S_DONE;
      end
      S_ECLR: begin
        reg_cs_stat_o = 1'b1;
        reg_wr_o      = 1'b1;
        state_d       = abort_any ? S_DONE : S_POLL;
      end
      S_READ: begin
        reg_cs_data_o = 1'b1;
        reg_rd_o      = 1'b1;
        state_d       = S_WRITE;
      end
      S_WRITE: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          if (rem_q == LEN_BITS'(1)) state_d = S_DONE;
          else state_d = abort_any ? S_DONE : S_POLL;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // transfer datapath, status flags and interrupt
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      irq_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q <= base_i;
        rem_q  <= len_i;
        cnt_q  <= '0;
        err_q  <= 1'b0;
        tmo_q  <= 1'b0;
      end
      if (state_q == S_POLL && stat_err) err_q <= 1'b1;
      if (state_q == S_POLL && !stat_err && stat_empty && tmo_hit)
        tmo_q <= 1'b1;
      if (state_q == S_READ) wdata_q <= reg_d_i;
      if (byte_done) begin
        addr_q <= addr_q + ADDR_BITS'(1);
        cnt_q  <= cnt_q + LEN_BITS'(1);
        rem_q  <= rem_q - LEN_BITS'(1);
      end
      if (state_q == S_DONE)          irq_q <= 1'b1;
      else if (irq_ack_i || start_ok) irq_q <= 1'b0;
      if (state_q == S_DONE || start_ok)         abort_q <= 1'b0;
      else if (abort_i && state_q != S_IDLE)     abort_q <= 1'b1;
    end
  end

  assign reg_d_o     = 8'h00;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = cnt_q;
  assign err_o       = err_q;
  assign tmo_o       = tmo_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_rxdma.sv
// tb_uart_rxdma: UART host + SRAM models around uart_rxdma.
// Expected SRAM contents, counts and latencies come from arithmetic models.
module tb_uart_rxdma;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [20:0] base_i = '0;
  logic [15:0] len_i = '0;
  logic [15:0] tmo_i = '0;
  logic        irq_ack_i = 1'b0;
  logic        busy_o, done_o, irq_o, err_o, tmo_o;
  logic [15:0] count_o;
  logic [7:0]  reg_d_i, reg_d_o;
  logic        reg_rd_o, reg_wr_o, reg_cs_stat_o, reg_cs_data_o;
  logic        mem_req_o, mem_ack_i;
  logic [20:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;

  int vecs = 0;
  int errs = 0;

  uart_rxdma dut (
    .clk(clk), .resetn(resetn),
    .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .len_i(len_i), .tmo_i(tmo_i),
    .irq_ack_i(irq_ack_i),
    .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o),
    .count_o(count_o), .err_o(err_o), .tmo_o(tmo_o),
    .reg_d_i(reg_d_i), .reg_d_o(reg_d_o),
    .reg_rd_o(reg_rd_o), .reg_wr_o(reg_wr_o),
    .reg_cs_stat_o(reg_cs_stat_o), .reg_cs_data_o(reg_cs_data_o),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  // UART host model: RX FIFO plus a framing-error flag
  logic [7:0] fifo_mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int ferr_set = 0;
  int ferr_clr = 0;
  int eclr_cnt = 0;
  int eclr_bad = 0;

  always_comb begin
    reg_d_i = 8'h00;
    if (reg_cs_stat_o)
      reg_d_i = {(rd_ptr == wr_ptr), 1'b0, 1'b0, (ferr_set != ferr_clr), 4'h0};
    else if (reg_cs_data_o)
      reg_d_i = fifo_mem[rd_ptr & 255];
  end

  // SRAM model with programmable ack delay
  int ack_dly = 0;
  int wcnt = 0;
  assign mem_ack_i = mem_req_o && (wcnt >= ack_dly);

  logic [20:0] wlog_a [0:255];
  logic [7:0]  wlog_d [0:255];
  int wr_cnt = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int last_done_cyc = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;
  int cs_both = 0;
  int viol = 0;
  bit held = 1'b0;
  logic [20:0] h_addr = '0;
  logic [7:0]  h_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_cs_data_o && reg_rd_o) rd_ptr <= rd_ptr + 1;
    if (reg_cs_stat_o && reg_wr_o) begin
      ferr_clr <= ferr_set;
      eclr_cnt <= eclr_cnt + 1;
      if (reg_d_o !== 8'h00) eclr_bad <= eclr_bad + 1;
    end
    if (reg_cs_stat_o && reg_cs_data_o) cs_both <= cs_both + 1;
    if (reg_rd_o || reg_wr_o || mem_req_o) strobe_cnt <= strobe_cnt + 1;
    if (mem_req_o && !mem_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req_o && held &&
        (mem_addr_o !== h_addr || mem_wdata_o !== h_data))
      viol <= viol + 1;
    held   <= mem_req_o && !mem_ack_i;
    h_addr <= mem_addr_o;
    h_data <= mem_wdata_o;
    if (mem_req_o && mem_ack_i) begin
      wlog_a[wr_cnt & 255] <= mem_addr_o;
      wlog_d[wr_cnt & 255] <= mem_wdata_o;
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
    if (done_o) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr & 255] = b;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic run(input logic [20:0] b, input logic [15:0] l,
                     input logic [15:0] t, input bit inj, input int ab,
                     input bit fe, output bit ok, output int k);
    int w0, r0;
    bit abd, fed;
    w0 = wr_cnt; r0 = rd_ptr; abd = 0; fed = 0; ok = 0; k = 0;
    base_i = b; len_i = l; tmo_i = t; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      start_i = 1'b0;
      abort_i = 1'b0;
      if (done_o) begin ok = 1; k = i + 1; break; end
      if (inj && i == 4) begin
        start_i = 1'b1; base_i = ~b; len_i = 16'd3;
      end
      if (ab > 0 && !abd && mem_req_o && (wr_cnt - w0) == ab - 1) begin
        abort_i = 1'b1; abd = 1;
      end
      if (fe && !fed && (rd_ptr - r0) == 1) begin
        ferr_set++; fed = 1;
      end
      tick();
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    resetn = 1'b0;
    tick(); tick();
    flags = {busy_o, done_o, irq_o, err_o, tmo_o, reg_rd_o, reg_wr_o,
             reg_cs_stat_o, reg_cs_data_o, mem_req_o};
    vecs++;
    if (flags !== 10'h0) begin
      errs++; $display("FAIL reset_flags got %b want 0", flags);
    end
    vecs++;
    if (count_o !== 16'h0) begin
      errs++; $display("FAIL reset_count got %0d want 0", count_o);
    end
    vecs++;
    if (mem_addr_o !== 21'h0 || mem_wdata_o !== 8'h0 || reg_d_o !== 8'h0) begin
      errs++;
      $display("FAIL reset_data got %h/%h/%h want 0", mem_addr_o, mem_wdata_o, reg_d_o);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok; int k, w0;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    flush(); ack_dly = 0; w0 = wr_cnt;
    foreach (exp[i]) push(exp[i]);
    run(21'h1000, 16'd4, 16'd0, 0, 0, 0, ok, k);
    vecs++;
    if (!ok || k != 13) begin
      errs++; $display("FAIL basic_latency got %0d want 13 (ok=%0d)", k, ok);
    end
    tick();
    vecs++;
    if (count_o !== 16'd4) begin
      errs++; $display("FAIL basic_count got %0d want 4", count_o);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (wlog_a[(w0 + i) & 255] !== 21'h1000 + 21'(i) ||
          wlog_d[(w0 + i) & 255] !== exp[i]) begin
        errs++;
        $display("FAIL basic_mem%0d got %h:%h want %h:%h", i,
                 wlog_a[(w0 + i) & 255], wlog_d[(w0 + i) & 255],
                 21'h1000 + 21'(i), exp[i]);
      end
    end
    vecs++;
    if (last_done_cyc - last_wr_cyc != 1) begin
      errs++;
      $display("FAIL basic_done_gap got %0d want 1", last_done_cyc - last_wr_cyc);
    end
    vecs++;
    if (busy_o !== 1'b0 || irq_o !== 1'b1) begin
      errs++; $display("FAIL basic_status got busy=%b irq=%b want 0/1", busy_o, irq_o);
    end
  endtask

  task automatic test_irq();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    vecs++;
    if (irq_o !== 1'b0) begin
      errs++; $display("FAIL irq_ack got %b want 0", irq_o);
    end
  endtask

  task automatic test_len0();
    bit ok; int k, s0, d0;
    s0 = strobe_cnt; d0 = done_cnt;
    run(21'h55, 16'd0, 16'd0, 0, 0, 0, ok, k);
    vecs++;
    if (!ok || k > 2) begin
      errs++; $display("FAIL len0_latency got %0d want <=2 (ok=%0d)", k, ok);
    end
    tick();
    vecs++;
    if (strobe_cnt != s0 || done_cnt != d0 + 1 || count_o !== 16'd0) begin
      errs++;
      $display("FAIL len0_side got strobes=%0d dones=%0d cnt=%0d want 0/1/0",
               strobe_cnt - s0, done_cnt - d0, count_o);
    end
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
  endtask

  task automatic test_random();
    bit ok; int k, w0, r0, len, extra, bad;
    logic [20:0] base;
    logic [7:0] bytes [$];
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 12);
      extra = $urandom_range(0, 2);
      ack_dly = $urandom_range(0, 5);
      base = (it % 3 == 1) ? 21'h1FFFFE : 21'($urandom);
      bytes.delete();
      flush();
      for (int i = 0; i < len + extra; i++) bytes.push_back(8'($urandom));
      foreach (bytes[i]) push(bytes[i]);
      w0 = wr_cnt; r0 = rd_ptr;
      run(base, 16'(len), 16'd0, it[0], 0, 0, ok, k);
      vecs++;
      if (!ok || k != (3 + ack_dly) * len + 1) begin
        errs++;
        $display("FAIL rand%0d_latency got %0d want %0d", it, k,
                 (3 + ack_dly) * len + 1);
      end
      tick();
      vecs++;
      if (count_o !== 16'(len) || wr_cnt - w0 != len || rd_ptr - r0 != len) begin
        errs++;
        $display("FAIL rand%0d_count got %0d/%0d/%0d want %0d", it,
                 count_o, wr_cnt - w0, rd_ptr - r0, len);
      end
      bad = 0;
      for (int i = 0; i < len; i++)
        if (wlog_a[(w0 + i) & 255] !== base + 21'(i) ||
            wlog_d[(w0 + i) & 255] !== bytes[i]) bad++;
      vecs++;
      if (bad != 0) begin
        errs++; $display("FAIL rand%0d_mem got %0d bad bytes want 0", it, bad);
      end
      vecs++;
      if (wr_ptr - rd_ptr != extra || viol != 0 || err_o !== 1'b0 ||
          tmo_o !== 1'b0 || cs_both != 0) begin
        errs++;
        $display("FAIL rand%0d_misc got left=%0d viol=%0d err=%b tmo=%b cs=%0d want %0d/0/0/0/0",
                 it, wr_ptr - rd_ptr, viol, err_o, tmo_o, cs_both, extra);
      end
      irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
    end
  endtask

  task automatic test_ferr();
    bit ok; int k, w0, e0, bad;
    logic [7:0] exp [3];
    exp = '{8'hA5, 8'h5A, 8'hC3};
    flush(); ack_dly = 0; w0 = wr_cnt; e0 = eclr_cnt;
    foreach (exp[i]) push(exp[i]);
    run(21'h0400, 16'd3, 16'd0, 0, 0, 1, ok, k);
    vecs++;
    if (!ok || k != 12) begin
      errs++; $display("FAIL ferr_latency got %0d want 12", k);
    end
    tick();
    vecs++;
    if (eclr_cnt - e0 != 1 || eclr_bad != 0 || err_o !== 1'b1) begin
      errs++;
      $display("FAIL ferr_eclr got n=%0d bad=%0d err=%b want 1/0/1",
               eclr_cnt - e0, eclr_bad, err_o);
    end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (wlog_d[(w0 + i) & 255] !== exp[i] ||
          wlog_a[(w0 + i) & 255] !== 21'h0400 + 21'(i)) bad++;
    vecs++;
    if (count_o !== 16'd3 || bad != 0) begin
      errs++; $display("FAIL ferr_data got cnt=%0d bad=%0d want 3/0", count_o, bad);
    end
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
  endtask

  task automatic test_abort();
    bit ok; int k, w0;
    flush(); ack_dly = 3; w0 = wr_cnt;
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    run(21'h2000, 16'd8, 16'd0, 0, 2, 0, ok, k);
    vecs++;
    if (!ok) begin
      errs++; $display("FAIL abort_done got none want done");
    end
    tick();
    vecs++;
    if (count_o !== 16'd2 || wr_cnt - w0 != 2 || wr_ptr - rd_ptr != 6) begin
      errs++;
      $display("FAIL abort_count got %0d/%0d left=%0d want 2/2/6",
               count_o, wr_cnt - w0, wr_ptr - rd_ptr);
    end
    vecs++;
    if (last_done_cyc - last_wr_cyc != 1 ||
        wlog_d[(w0 + 1) & 255] !== 8'h81) begin
      errs++;
      $display("FAIL abort_tail got gap=%0d d=%h want 1/81",
               last_done_cyc - last_wr_cyc, wlog_d[(w0 + 1) & 255]);
    end
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
  endtask

`ifdef UART_RXDMA_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int k, gap;
    flush(); ack_dly = 0;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    run(21'h0300, 16'd8, 16'd100, 0, 0, 0, ok, k);
    tick();
    gap = last_done_cyc - last_wr_cyc;
    vecs++;
    if (!ok || tmo_o !== 1'b1 || count_o !== 16'd3) begin
      errs++;
      $display("FAIL tmo_end got ok=%0d tmo=%b cnt=%0d want 1/1/3", ok, tmo_o, count_o);
    end
    vecs++;
    if (gap < 99 || gap > 102) begin
      errs++; $display("FAIL tmo_gap got %0d want ~100", gap);
    end
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    flush(); ack_dly = 5; seen = 0;
    for (int i = 0; i < 4; i++) push(8'(i));
    base_i = 21'h10; len_i = 16'd4; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) begin seen = 1; break; end
      tick();
    end
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL rstmid_req got 0 want 1");
    end
    resetn = 1'b0;
    tick();
    vecs++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errs++; $display("FAIL rstmid_idle got req=%b busy=%b want 0/0", mem_req_o, busy_o);
    end
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_irq();
    test_len0();
    test_random();
    test_ferr();
    test_abort();
`ifdef UART_RXDMA_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
